clint_ctrl: RTL



---
 rtl/clint_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/clint_ctrl.sv
// clint_ctrl: core-local interrupt controller sequencer.
// Detects ecall/ebreak/mret in execute and pending external interrupts,
// then walks the machine-mode CSR updates one write per cycle before
// strobing a PC redirect.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   inst_i, inst_addr_i           instruction in execute and its address
//   int_flag_i                    level external interrupt request
//   clint_csr_mtvec/mepc/mstatus  live CSR values
//   clint_wr_en_o/addr_o/data_o   CSR write port (registered)
//   hold_flag_o                   pipeline stall request (combinational)
//   int_assert_o, int_addr_o      redirect strobe and target (registered)
module clint_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        int_flag_i,
  input  logic [31:0] clint_csr_mtvec,
  input  logic [31:0] clint_csr_mepc,
  input  logic [31:0] clint_csr_mstatus,
  output logic        clint_wr_en_o,
  output logic [31:0] clint_wr_addr_o,
  output logic [31:0] clint_wr_data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, ASSERT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        mret_q, mret_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;

  logic is_ecall, is_ebreak, is_mret, is_async, trigger;

  assign is_ecall  = (inst_i == 32'h0000_0073);
  assign is_ebreak = (inst_i == 32'h0010_0073);
  assign is_mret   = (inst_i == 32'h3020_0073);
  assign is_async  = int_flag_i && clint_csr_mstatus[3];
  assign trigger   = (state_q == IDLE) && (is_ecall || is_ebreak || is_mret || is_async);

  // State and latched trap context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      mret_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      mret_q       <= mret_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  // Next state; trigger inputs are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    mret_d  = mret_q;
    unique case (state_q)
      IDLE: begin
        if (is_ecall || is_ebreak) begin
          state_d = W_MEPC;
          cause_d = is_ecall ? 32'd11 : 32'd3;
          epc_d   = inst_addr_i;
          mret_d  = 1'b0;
        end else if (is_mret) begin
          state_d = W_MRET;
          mret_d  = 1'b1;
        end else if (is_async) begin
          state_d = W_MEPC;
          cause_d = 32'h8000_000B;
          epc_d   = inst_addr_i;
          mret_d  = 1'b0;
        end
      end
      W_MEPC:    state_d = W_MSTATUS;
      W_MSTATUS: state_d = W_MCAUSE;
      W_MCAUSE:  state_d = ASSERT;
      W_MRET:    state_d = ASSERT;
      ASSERT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so each
  // value appears during the cycle its state is occupied.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    unique case (state_d)
      W_MEPC: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 32'h341;
        wr_data_d = epc_d;
      end
      W_MSTATUS: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 32'h300;
        wr_data_d = clint_csr_mstatus;
        wr_data_d[7] = clint_csr_mstatus[3];
        wr_data_d[3] = 1'b0;
      end
      W_MCAUSE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 32'h342;
        wr_data_d = cause_d;
      end
      W_MRET: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 32'h300;
        wr_data_d = clint_csr_mstatus;
        wr_data_d[3] = clint_csr_mstatus[7];
        wr_data_d[7] = 1'b1;
      end
      ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = mret_d ? clint_csr_mepc : clint_csr_mtvec;
      end
      default: ;
    endcase
  end

  assign clint_wr_en_o   = wr_en_q;
  assign clint_wr_addr_o = wr_addr_q;
  assign clint_wr_data_o = wr_data_q;
  assign int_assert_o    = int_assert_q;
  assign int_addr_o      = int_addr_q;
  assign hold_flag_o     = rst_n && (trigger || (state_q != IDLE));

endmodule
